gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
Synthesizable counterpart to the gate stimulus benches. It sweeps every input combination of an N-input combinational gate under test and samples the gate's output. Each response is compared against a parameterized expected truth table. Results are reported as pass/fail, an error count, a per-pattern mismatch mask and the first failing index, so gate checks run in hardware or in a self-checking simulation without manual waveform inspection.

Parameters:
N_IN, 3, number of gate inputs; stim width; 2**N_IN patterns swept
HOLD_CYCLES, 4, clock cycles each pattern is held before the next; must be >= 1
EXPECTED, 8'h7F, expected truth table, width 2**N_IN; bit i = expected resp for stim == i (default = 3-input NAND)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a sweep; honoured only in IDLE or DONE
abort  input  1  synchronous cancel of a running sweep
resp  input  1  output of gate under test (F)
stim  output  N_IN  drive to gate inputs; MSB = a, then b, then c, ...
busy  output  1  sweep in progress
done  output  1  sweep complete; held until next start
pass  output  1  done && err_count == 0
err_count  output  N_IN+1  number of mismatching patterns
err_mask  output  2**N_IN  bit i set if pattern i mismatched
first_fail  output  N_IN  lowest failing pattern index; 0 if none

Behaviour:
- Reset: rst_n low clears all outputs to 0 immediately, regardless of clock, and sets state IDLE. This applies mid-sweep with no partial results retained. After release, the block stays in IDLE until start.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0, stim=0. When start=1 at an edge: go to RUN, idx=0, hold_cnt=0, clear err_count, err_mask and first_fail. stim=0 is visible from that edge.
- RUN: busy=1. stim = idx. hold_cnt increments each edge.
  - At the edge where hold_cnt == HOLD_CYCLES-1, sample resp and compare with EXPECTED[idx].
  - On mismatch: set err_mask[idx] and increment err_count. If err_count was 0, load first_fail = idx.
  - Then hold_cnt=0 and idx increments.
  - With HOLD_CYCLES=1, each pattern lasts exactly one cycle and is sampled at its only edge. This is legal because the DUT is combinational.
- Last pattern: when idx == 2**N_IN-1 is sampled, go to DONE. stim returns to 0, busy=0, done=1.
  - Sweep latency is fixed: done is asserted 2**N_IN * HOLD_CYCLES edges after the start edge (32 for the defaults).
- DONE: done, pass and all results held stable. start=1 re-enters RUN exactly as from IDLE, with done dropping on that same edge.
- start while in RUN: ignored.
- abort=1 in RUN: go to IDLE at that edge. busy=0, done=0, stim=0, results cleared. abort has priority over a coinciding sample. In IDLE and DONE, abort is ignored.
- pass is combinational from registered done and err_count; it is never 1 outside DONE.
- err_count cannot overflow: its maximum is 2**N_IN, and N_IN+1 bits hold it.

Test Plan:
1. Correct NAND DUT (resp = ~(a&b&c)), defaults, start pulse at cycle 0.
   -> stim steps 0..7, 4 cycles each.
   -> done=1 after edge 32; pass=1, err_count=0, err_mask=0x00, first_fail=0.
2. AND DUT substituted, EXPECTED=8'h7F.
   -> all 8 patterns mismatch: err_count=8, err_mask=0xFF, first_fail=0, pass=0.
3. resp stuck at 1.
   -> only pattern 7 fails: err_count=1, err_mask=0x80, first_fail=7, pass=0.
4. Repeated start during a sweep, then after completion.
   -> start at cycle 10 has no effect; done still at edge 32.
   -> start in DONE at cycle 40 drops done and restarts; second done at edge 72 with identical results.
5. rst_n low at cycle 13 (asynchronous, between edges).
   -> stim, busy and all results go to 0 immediately.
   -> after release, no activity until start; a following clean sweep passes.
6. abort at cycle 20, plus a HOLD_CYCLES=1 build.
   -> abort returns to IDLE next edge: busy=0, done=0, stim=0.
   -> with HOLD_CYCLES=1, a correct NAND sweep sets done after edge 8 with pass=1.

Source files
------------

// File: rtl/gate_response_checker.sv
// gate_response_checker: sweeps all input patterns of an N-input gate and checks each response against a truth table
module gate_response_checker #(
  parameter int N_IN = 3,
  parameter int HOLD_CYCLES = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'h7F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 resp,
  output logic [N_IN-1:0]      stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [2**N_IN-1:0]   err_mask,
  output logic [N_IN-1:0]      first_fail
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [N_IN-1:0] idx;
  logic [HW-1:0] hold_cnt;
  logic sample, miss;
  assign sample = hold_cnt == HW'(HOLD_CYCLES - 1);
  assign miss = resp != EXPECTED[idx];
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  assign stim = busy ? idx : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      hold_cnt <= '0;
      err_count <= '0;
      err_mask <= '0;
      first_fail <= '0;
    end else if (state == RUN) begin
      if (abort) begin
        state <= IDLE;
        idx <= '0;
        hold_cnt <= '0;
        err_count <= '0;
        err_mask <= '0;
        first_fail <= '0;
      end else if (sample) begin
        hold_cnt <= '0;
        idx <= idx + N_IN'(1);
        if (miss) begin
          err_mask[idx] <= 1'b1;
          err_count <= err_count + (N_IN+1)'(1);
          if (err_count == '0) first_fail <= idx;
        end
        if (idx == '1) state <= DONE;
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end else if (start) begin
      // restart from IDLE or DONE wipes previous results on the same edge
      state <= RUN;
      idx <= '0;
      hold_cnt <= '0;
      err_count <= '0;
      err_mask <= '0;
      first_fail <= '0;
    end
  end
endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: randomized gate truth tables against a table-level reference model
module tb_gate_response_checker;
  logic clk, rst_n, start, abort, start1, abort1;
  logic [7:0] gate_a, gate_b;
  logic resp, resp1;
  logic [2:0] stim, stim1, first_fail, first_fail1;
  logic busy, done, pass, busy1, done1, pass1;
  logic [3:0] err_count, err_count1;
  logic [7:0] err_mask, err_mask1;
  int n_cmp = 0, n_bad = 0;
  localparam logic [7:0] NAND3 = 8'h7F;

  assign resp = gate_a[stim];
  assign resp1 = gate_b[stim1];

  gate_response_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .resp(resp),
    .stim(stim), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_mask(err_mask), .first_fail(first_fail)
  );

  gate_response_checker #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .resp(resp1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1), .err_mask(err_mask1), .first_fail(first_fail1)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] m_mask(input logic [7:0] tt);
    logic [7:0] m;
    for (int p = 0; p < 8; p++) m[p] = tt[p] != NAND3[p];
    return m;
  endfunction

  function automatic logic [3:0] m_count(input logic [7:0] tt);
    int c = 0;
    for (int p = 0; p < 8; p++) if (tt[p] != NAND3[p]) c++;
    return 4'(c);
  endfunction

  function automatic logic [2:0] m_first(input logic [7:0] tt);
    for (int p = 0; p < 8; p++) if (tt[p] != NAND3[p]) return 3'(p);
    return 3'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(inout int lat, inout bit stim_ok, input int hold);
    while (!done && lat < 200) begin
      if (busy && stim !== 3'(lat / hold)) stim_ok = 0;
      tick();
      lat++;
    end
  endtask

  task automatic sweep_a(input logic [7:0] tt, output int lat, output bit stim_ok);
    gate_a = tt;
    start = 1;
    tick();
    start = 0;
    lat = 0;
    stim_ok = 1;
    wait_done_a(lat, stim_ok, 4);
  endtask

  task automatic check_a(input string nm, input logic [7:0] tt, input int lat, input bit stim_ok);
    n_cmp++;
    if (lat !== 32) begin n_bad++; $display("FAIL %s latency got %0d want 32", nm, lat); end
    n_cmp++;
    if (!stim_ok) begin n_bad++; $display("FAIL %s stim sequence got wrong pattern want idx=cycle/4", nm); end
    n_cmp++;
    if ({pass, err_count, err_mask, first_fail, stim, busy} !== {m_count(tt) == 0, m_count(tt), m_mask(tt), m_first(tt), 3'd0, 1'b0})
      begin n_bad++; $display("FAIL %s results got pass=%b cnt=%0d mask=%h ff=%0d stim=%0d busy=%b want pass=%b cnt=%0d mask=%h ff=%0d stim=0 busy=0",
        nm, pass, err_count, err_mask, first_fail, stim, busy, m_count(tt) == 0, m_count(tt), m_mask(tt), m_first(tt)); end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({stim, busy, done, pass, err_count, err_mask, first_fail} !== '0)
      begin n_bad++; $display("FAIL reset outputs got %h want 0", {stim, busy, done, pass, err_count, err_mask, first_fail}); end
    #3 rst_n = 1;
    repeat (3) tick();
    n_cmp++;
    if ({busy, done, stim} !== '0) begin n_bad++; $display("FAIL reset_idle got busy=%b done=%b stim=%0d want 0", busy, done, stim); end
  endtask

  task automatic test_nand();
    int lat; bit ok;
    sweep_a(NAND3, lat, ok);
    check_a("nand", NAND3, lat, ok);
  endtask

  task automatic test_and();
    int lat; bit ok;
    sweep_a(8'h80, lat, ok);
    check_a("and", 8'h80, lat, ok);
  endtask

  task automatic test_stuck1();
    int lat; bit ok;
    sweep_a(8'hFF, lat, ok);
    check_a("stuck1", 8'hFF, lat, ok);
  endtask

  task automatic test_random();
    int lat; bit ok;
    logic [7:0] tt;
    for (int r = 0; r < 6; r++) begin
      tt = 8'($urandom);
      sweep_a(tt, lat, ok);
      check_a($sformatf("rand%0d_%h", r, tt), tt, lat, ok);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit ok;
    logic [7:0] tt;
    tt = 8'($urandom) | 8'h01;
    gate_a = tt;
    start = 1;
    tick();
    start = 0;
    lat = 0;
    ok = 1;
    repeat (9) begin tick(); lat++; end
    start = 1;
    tick();
    lat++;
    start = 0;
    wait_done_a(lat, ok, 4);
    check_a("start_in_run", tt, lat, ok);
    repeat (7) tick();
    n_cmp++;
    if ({done, err_mask} !== {1'b1, m_mask(tt)}) begin n_bad++; $display("FAIL done_hold got done=%b mask=%h want 1 %h", done, err_mask, m_mask(tt)); end
    abort = 1;
    tick();
    abort = 0;
    n_cmp++;
    if ({done, err_count} !== {1'b1, m_count(tt)}) begin n_bad++; $display("FAIL abort_in_done got done=%b cnt=%0d want 1 %0d", done, err_count, m_count(tt)); end
    start = 1;
    tick();
    start = 0;
    n_cmp++;
    if ({done, busy, err_count, stim} !== {1'b0, 1'b1, 4'd0, 3'd0}) begin n_bad++; $display("FAIL restart_edge got done=%b busy=%b cnt=%0d stim=%0d want 0 1 0 0", done, busy, err_count, stim); end
    lat = 0;
    ok = 1;
    wait_done_a(lat, ok, 4);
    check_a("restart_done", tt, lat, ok);
  endtask

  task automatic test_async_reset();
    int lat; bit ok;
    gate_a = 8'h00;
    start = 1;
    tick();
    start = 0;
    repeat (13) tick();
    n_cmp++;
    if ({busy, err_count} !== {1'b1, 4'd3}) begin n_bad++; $display("FAIL pre_reset got busy=%b cnt=%0d want 1 3", busy, err_count); end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({stim, busy, done, pass, err_count, err_mask, first_fail} !== '0)
      begin n_bad++; $display("FAIL async_reset got %h want 0", {stim, busy, done, pass, err_count, err_mask, first_fail}); end
    #3 rst_n = 1;
    repeat (5) tick();
    n_cmp++;
    if ({busy, done, stim, err_count} !== '0) begin n_bad++; $display("FAIL post_reset_idle got busy=%b done=%b stim=%0d cnt=%0d want 0", busy, done, stim, err_count); end
    sweep_a(NAND3, lat, ok);
    check_a("post_reset_sweep", NAND3, lat, ok);
  endtask

  task automatic test_abort();
    gate_a = 8'h80;
    start = 1;
    tick();
    start = 0;
    repeat (19) tick();
    n_cmp++;
    if ({busy, err_count, err_mask} !== {1'b1, 4'd4, 8'h0F}) begin n_bad++; $display("FAIL pre_abort got busy=%b cnt=%0d mask=%h want 1 4 0f", busy, err_count, err_mask); end
    abort = 1;
    tick();
    abort = 0;
    n_cmp++;
    if ({busy, done, pass, stim, err_count, err_mask, first_fail} !== '0)
      begin n_bad++; $display("FAIL abort got busy=%b done=%b stim=%0d cnt=%0d mask=%h want 0", busy, done, stim, err_count, err_mask); end
    repeat (4) tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_hold1();
    int lat;
    bit ok;
    logic [7:0] tt;
    for (int r = 0; r < 3; r++) begin
      tt = r == 0 ? NAND3 : 8'($urandom);
      gate_b = tt;
      start1 = 1;
      tick();
      start1 = 0;
      lat = 0;
      ok = 1;
      while (!done1 && lat < 100) begin
        if (busy1 && stim1 !== 3'(lat)) ok = 0;
        tick();
        lat++;
      end
      n_cmp++;
      if (lat !== 8 || !ok) begin n_bad++; $display("FAIL hold1_%0d latency got %0d stim_ok=%b want 8 1", r, lat, ok); end
      n_cmp++;
      if ({pass1, err_count1, err_mask1, first_fail1} !== {m_count(tt) == 0, m_count(tt), m_mask(tt), m_first(tt)})
        begin n_bad++; $display("FAIL hold1_%0d results got pass=%b cnt=%0d mask=%h ff=%0d want pass=%b cnt=%0d mask=%h ff=%0d",
          r, pass1, err_count1, err_mask1, first_fail1, m_count(tt) == 0, m_count(tt), m_mask(tt), m_first(tt)); end
    end
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; start1 = 0; abort1 = 0;
    gate_a = NAND3; gate_b = NAND3;
    #12;
    test_reset();
    test_nand();
    test_and();
    test_stuck1();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_abort();
    test_hold1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
